freq_meas_ctrl: RTL and testbench

Measurement sequencer for the equal-precision frequency meter. It generates the software-programmed gate window and aligns both of its edges to rising edges of the measured signal. It counts reference-clock cycles and measured-signal cycles over that window, then latches the result pair and raises a host interrupt. It sits between the MCU register/interrupt logic and the measured-signal input, all in the 100 MHz domain.

---
 rtl/freq_meas_ctrl.sv | 166 ++++++++++++++++
 tb/tb_freq_meas_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/freq_meas_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : freq_meas_ctrl
// Purpose  : Equal-precision frequency meter sequencer. It aligns the gate to
//            sig_test edges, counts both clocks and latches the result pair.
// Revision : 1.0  initial release
// ============================================================================
module freq_meas_ctrl #(
    parameter int GATE_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic              clk_100M,
    input  logic              rst_n,
    input  logic              sig_test,
    input  logic              start,
    input  logic              cont_mode,
    input  logic [GATE_W-1:0] gate_len,
    input  logic [GATE_W-1:0] timeout_len,
    input  logic              irq_ack,
    output logic              busy,
    output logic              done_irq,
    output logic              timeout_flag,
    output logic [CNT_W-1:0]  base_count,
    output logic [CNT_W-1:0]  test_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        COUNT = 2'd2,
        CLOSE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [GATE_W-1:0] GATE_ONE = GATE_W'(1);

    state_t            state_q;
    logic              sync1_q, sync2_q, prev_q;
    logic [CNT_W-1:0]  base_cnt_q, test_cnt_q;
    logic [GATE_W-1:0] gate_cnt_q, tmo_cnt_q;
    logic              busy_q, done_q, tmo_flag_q;
    logic [CNT_W-1:0]  base_res_q, test_res_q;

    logic              rise;
    logic              gate_last;
    logic              tmo_hit;
    logic [CNT_W-1:0]  base_inc, test_inc;

    assign rise      = sync2_q & ~prev_q;
    // A zero gate length behaves as a one-cycle gate.
    assign gate_last = (gate_len == '0) ? (gate_cnt_q == '0)
                                        : (gate_cnt_q == gate_len - GATE_ONE);
    assign tmo_hit   = (timeout_len != '0) && (tmo_cnt_q == timeout_len - GATE_ONE);
    assign base_inc  = (base_cnt_q == CNT_MAX) ? base_cnt_q : base_cnt_q + CNT_W'(1);
    assign test_inc  = (test_cnt_q == CNT_MAX) ? test_cnt_q : test_cnt_q + CNT_W'(1);

    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            prev_q     <= 1'b0;
            base_cnt_q <= '0;
            test_cnt_q <= '0;
            gate_cnt_q <= '0;
            tmo_cnt_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            tmo_flag_q <= 1'b0;
            base_res_q <= '0;
            test_res_q <= '0;
        end else begin
            sync1_q <= sig_test;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;

            // Any completion below assigns later and so wins over the ack.
            if (irq_ack) begin
                done_q     <= 1'b0;
                tmo_flag_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q   <= ARM;
                        busy_q    <= 1'b1;
                        tmo_cnt_q <= '0;
                    end
                end

                ARM: begin
                    if (rise) begin
                        state_q    <= COUNT;
                        base_cnt_q <= '0;
                        test_cnt_q <= '0;
                        gate_cnt_q <= '0;
                    end else if (tmo_hit) begin
                        state_q    <= IDLE;
                        busy_q     <= 1'b0;
                        base_res_q <= '0;
                        test_res_q <= '0;
                        done_q     <= 1'b1;
                        tmo_flag_q <= 1'b1;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + GATE_ONE;
                    end
                end

                COUNT: begin
                    base_cnt_q <= base_inc;
                    gate_cnt_q <= gate_cnt_q + GATE_ONE;
                    if (rise) begin
                        test_cnt_q <= test_inc;
                    end
                    if (gate_last) begin
                        state_q   <= CLOSE;
                        tmo_cnt_q <= '0;
                    end
                end

                CLOSE: begin
                    if (rise) begin
                        // The closing edge itself is included in both counts.
                        base_res_q <= base_inc;
                        test_res_q <= test_inc;
                        done_q     <= 1'b1;
                        tmo_flag_q <= 1'b0;
                        if (cont_mode) begin
                            state_q    <= COUNT;
                            base_cnt_q <= '0;
                            test_cnt_q <= '0;
                            gate_cnt_q <= '0;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else if (tmo_hit) begin
                        state_q    <= IDLE;
                        busy_q     <= 1'b0;
                        base_res_q <= '0;
                        test_res_q <= '0;
                        done_q     <= 1'b1;
                        tmo_flag_q <= 1'b1;
                    end else begin
                        base_cnt_q <= base_inc;
                        tmo_cnt_q  <= tmo_cnt_q + GATE_ONE;
                    end
                end

                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy         = busy_q;
    assign done_irq     = done_q;
    assign timeout_flag = tmo_flag_q;
    assign base_count   = base_res_q;
    assign test_count   = test_res_q;

endmodule
`default_nettype wire

// File: tb/tb_freq_meas_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_freq_meas_ctrl
// Purpose  : Directed self-checking bench for freq_meas_ctrl.
// Revision : 1.0  initial release
// ============================================================================
module tb_freq_meas_ctrl;

    localparam int GATE_W = 32;
    localparam int CNT_W  = 32;

    logic              clk_100M = 1'b0;
    logic              rst_n    = 1'b0;
    logic              sig_test = 1'b0;
    logic              start    = 1'b0;
    logic              cont_mode = 1'b0;
    logic [GATE_W-1:0] gate_len = '0;
    logic [GATE_W-1:0] timeout_len = '0;
    logic              irq_ack  = 1'b0;
    logic              busy, done_irq, timeout_flag;
    logic [CNT_W-1:0]  base_count, test_count;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int period = 10;
    int ph     = 0;
    logic sig_en = 1'b0;

    freq_meas_ctrl #(.GATE_W(GATE_W), .CNT_W(CNT_W)) dut (
        .clk_100M     (clk_100M),
        .rst_n        (rst_n),
        .sig_test     (sig_test),
        .start        (start),
        .cont_mode    (cont_mode),
        .gate_len     (gate_len),
        .timeout_len  (timeout_len),
        .irq_ack      (irq_ack),
        .busy         (busy),
        .done_irq     (done_irq),
        .timeout_flag (timeout_flag),
        .base_count   (base_count),
        .test_count   (test_count)
    );

    always #5 clk_100M = ~clk_100M;
    always @(posedge clk_100M) cyc <= cyc + 1;

    // Square wave on sig_test, high for the first half of each period.
    always @(negedge clk_100M) begin
        if (!sig_en) begin
            sig_test <= 1'b0;
            ph       <= 0;
        end else begin
            ph       <= (ph >= period - 1) ? 0 : ph + 1;
            sig_test <= (ph < period / 2);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_100M);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic pulse_ack();
        irq_ack = 1'b1;
        tick(1);
        irq_ack = 1'b0;
    endtask

    task automatic wait_done(input int bound, input string tag);
        for (int i = 0; i < bound; i++) begin
            if (done_irq) break;
            tick(1);
        end
        if (!done_irq) check(tag, done_irq, 1);
    endtask

    int t_first;

    initial begin
        // Reset with sig_test toggling, then idle
        sig_en = 1'b1;
        period = 10;
        tick(20);
        rst_n = 1'b1;
        tick(200);
        check("rst_busy", busy, 0);
        check("rst_done", done_irq, 0);
        check("rst_tmo", timeout_flag, 0);
        check("rst_base", base_count, 0);
        check("rst_test", test_count, 0);

        // Single measurement, period 10, gate 95
        gate_len = 95;
        timeout_len = 0;
        pulse_start();
        check("arm_busy", busy, 1);
        wait_done(400, "single_wait");
        check("single_busy", busy, 0);
        check("single_base", base_count, 100);
        check("single_test", test_count, 10);
        check("single_tmo", timeout_flag, 0);

        // Gate boundary, with irq_ack held through start and the closing edge
        gate_len = 100;
        irq_ack = 1'b1;
        pulse_start();
        check("ack_start_done", done_irq, 0);
        check("ack_start_busy", busy, 1);
        for (int i = 0; i < 400; i++) begin
            if (!busy) break;
            tick(1);
        end
        check("bnd_busy", busy, 0);
        check("bnd_set_wins", done_irq, 1);
        check("bnd_base", base_count, 110);
        check("bnd_test", test_count, 11);
        tick(1);
        check("bnd_ack_clear", done_irq, 0);
        irq_ack = 1'b0;

        // start while busy is ignored
        gate_len = 95;
        pulse_start();
        tick(50);
        check("rs_busy", busy, 1);
        check("rs_hold_base", base_count, 110);
        pulse_start();
        wait_done(400, "rs_wait");
        check("rs_base", base_count, 100);
        check("rs_test", test_count, 10);
        tick(5);
        check("rs_no_restart", busy, 0);
        pulse_ack();
        check("rs_ack", done_irq, 0);

        // Timeout with sig_test held low
        sig_en = 1'b0;
        tick(10);
        timeout_len = 50;
        pulse_start();
        tick(49);
        check("tmo_early_done", done_irq, 0);
        check("tmo_early_busy", busy, 1);
        tick(1);
        check("tmo_done", done_irq, 1);
        check("tmo_flag", timeout_flag, 1);
        check("tmo_busy", busy, 0);
        check("tmo_base", base_count, 0);
        check("tmo_test", test_count, 0);
        pulse_ack();
        check("tmo_ack_done", done_irq, 0);
        check("tmo_ack_flag", timeout_flag, 0);
        timeout_len = 0;

        // Continuous mode, period 8, gate 20
        period = 8;
        sig_en = 1'b1;
        gate_len = 20;
        cont_mode = 1'b1;
        pulse_start();
        wait_done(400, "cont1_wait");
        t_first = cyc;
        check("cont1_base", base_count, 24);
        check("cont1_test", test_count, 3);
        check("cont1_busy", busy, 1);
        pulse_ack();
        wait_done(100, "cont2_wait");
        check("cont2_gap", cyc - t_first, 24);
        check("cont2_base", base_count, 24);
        check("cont2_test", test_count, 3);
        check("cont2_busy", busy, 1);
        cont_mode = 1'b0;
        pulse_ack();
        wait_done(100, "cont3_wait");
        check("cont3_base", base_count, 24);
        check("cont3_busy", busy, 0);
        pulse_ack();

        // Reset asserted while waiting in CLOSE
        period = 10;
        gate_len = 30;
        pulse_start();
        tick(16);
        sig_en = 1'b0;
        tick(60);
        check("cl_busy", busy, 1);
        check("cl_done", done_irq, 0);
        rst_n = 1'b0;
        #2;
        check("cl_rst_busy", busy, 0);
        check("cl_rst_base", base_count, 0);
        check("cl_rst_test", test_count, 0);
        tick(3);
        rst_n = 1'b1;
        sig_en = 1'b1;
        tick(50);
        check("cl_post_done", done_irq, 0);
        check("cl_post_busy", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
